// File: rtl/usig_offset_cal.sv
// Unsigned-to-signed sample conversion with on-demand zero-offset calibration.
// Calibration averages 2^CAL_LOG2 valid samples taken with the inverter idle.
//
// state | meaning
// ------+--------------------------------------------------------
// IDLE  | uncalibrated, converting with the current (mid-scale) offset
// CAL   | accumulating calibration samples, out_valid held low
// RUN   | calibrated, converting with the measured offset
module usig_offset_cal #(
  parameter int W_IN     = 16,
  parameter int CAL_LOG2 = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [W_IN-1:0] in_data,
  input  logic            in_valid,
  input  logic            cal_start,
  output logic [W_IN-1:0] out_data,
  output logic            out_valid,
  output logic [W_IN-1:0] offset,
  output logic            cal_done,
  output logic            cal_ok,
  output logic            busy
);

  localparam int ACC_W = W_IN + CAL_LOG2;
  localparam logic [W_IN-1:0] MID_SCALE = {1'b1, {(W_IN-1){1'b0}}};
  localparam logic [W_IN-1:0] SAT_POS   = {1'b0, {(W_IN-1){1'b1}}};
  localparam logic [W_IN-1:0] SAT_NEG   = {1'b1, {(W_IN-1){1'b0}}};

  typedef enum logic [1:0] {ST_IDLE, ST_CAL, ST_RUN} state_t;

  state_t                state_q, state_d;
  logic [ACC_W-1:0]      acc_q, acc_d;
  logic [CAL_LOG2-1:0]   cnt_q, cnt_d;
  logic [W_IN-1:0]       offset_q, offset_d;
  logic [W_IN-1:0]       out_data_q, out_data_d;
  logic                  out_valid_q, out_valid_d;
  logic                  cal_done_q, cal_done_d;
  logic                  cal_ok_q, cal_ok_d;

  logic signed [W_IN:0]  diff;
  logic [W_IN-1:0]       sat_data;
  logic [ACC_W-1:0]      acc_sum;

  // Difference is one bit wider than the inputs, so the two top bits
  // disagree exactly when the result does not fit in W_IN signed bits.
  always_comb begin
    diff = $signed({1'b0, in_data}) - $signed({1'b0, offset_q});
    if (diff[W_IN] != diff[W_IN-1]) begin
      sat_data = diff[W_IN] ? SAT_NEG : SAT_POS;
    end else begin
      sat_data = diff[W_IN-1:0];
    end
    acc_sum = acc_q + {{CAL_LOG2{1'b0}}, in_data};
  end

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    offset_d    = offset_q;
    out_data_d  = out_data_q;
    out_valid_d = 1'b0;
    cal_done_d  = 1'b0;
    cal_ok_d    = cal_ok_q;

    case (state_q)
      ST_IDLE, ST_RUN: begin
        out_valid_d = in_valid;
        if (in_valid) begin
          out_data_d = sat_data;
        end
        if (cal_start) begin
          state_d = ST_CAL;
          acc_d   = '0;
          cnt_d   = '0;
        end
      end
      ST_CAL: begin
        if (in_valid) begin
          if (cnt_q == {CAL_LOG2{1'b1}}) begin
            offset_d   = acc_sum[ACC_W-1:CAL_LOG2];
            cal_done_d = 1'b1;
            cal_ok_d   = 1'b1;
            state_d    = ST_RUN;
          end else begin
            acc_d = acc_sum;
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      offset_q    <= MID_SCALE;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      cal_done_q  <= 1'b0;
      cal_ok_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      offset_q    <= offset_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      cal_done_q  <= cal_done_d;
      cal_ok_q    <= cal_ok_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign offset    = offset_q;
  assign cal_done  = cal_done_q;
  assign cal_ok    = cal_ok_q;
  assign busy      = (state_q == ST_CAL);

endmodule

// File: tb/tb_usig_offset_cal.sv
// Directed bench for usig_offset_cal: an integer-arithmetic reference model
// checked every cycle, plus hand-computed literal checks per scenario.
module tb_usig_offset_cal;

  localparam int NCAL = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [15:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        cal_start = 1'b0;
  logic [15:0] out_data;
  logic        out_valid;
  logic [15:0] offset;
  logic        cal_done;
  logic        cal_ok;
  logic        busy;

  int tests = 0;
  int fails = 0;
  logic started = 1'b0;

  usig_offset_cal #(.W_IN(16), .CAL_LOG2(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .cal_start(cal_start), .out_data(out_data), .out_valid(out_valid),
    .offset(offset), .cal_done(cal_done), .cal_ok(cal_ok), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference model: plain integer sum/count, division for the average.
  logic        m_cal;
  int          m_n;
  int          m_sum;
  logic [15:0] e_offset;
  logic        e_ov, e_done, e_ok;
  logic [15:0] e_od;

  function automatic logic [15:0] sat16(input int v);
    if (v > 32767) return 16'h7FFF;
    if (v < -32768) return 16'h8000;
    return 16'(v);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cal <= 1'b0; m_n <= 0; m_sum <= 0; e_offset <= 16'h8000;
      e_ov <= 1'b0; e_od <= '0; e_done <= 1'b0; e_ok <= 1'b0;
    end else begin
      e_done <= 1'b0;
      if (!m_cal) begin
        e_ov <= in_valid;
        if (in_valid) e_od <= sat16(int'(in_data) - int'(e_offset));
        if (cal_start) begin
          m_cal <= 1'b1; m_n <= 0; m_sum <= 0;
        end
      end else begin
        e_ov <= 1'b0;
        if (in_valid) begin
          if (m_n + 1 == NCAL) begin
            e_offset <= 16'((m_sum + int'(in_data)) / NCAL);
            e_done <= 1'b1; e_ok <= 1'b1; m_cal <= 1'b0;
          end else begin
            m_sum <= m_sum + int'(in_data);
            m_n <= m_n + 1;
          end
        end
      end
    end
  end

  task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%04h expected 0x%04h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (started && rst_n) begin
      chk1("out_valid", out_valid, e_ov);
      if (e_ov) chk16("out_data", out_data, e_od);
      chk16("offset", offset, e_offset);
      chk1("cal_done", cal_done, e_done);
      chk1("cal_ok", cal_ok, e_ok);
      chk1("busy", busy, m_cal);
    end
  end

  task automatic cyc(input logic v, input logic [15:0] d, input logic cs);
    in_valid = v; in_data = d; cal_start = cs;
    @(posedge clk); #1;
    in_valid = 1'b0; cal_start = 1'b0;
  endtask

  // Start pulse (its own sample is converted) followed by NCAL valid samples.
  task automatic calibrate(input logic [15:0] d);
    cyc(1'b1, d, 1'b1);
    chk1("cal_busy_on", busy, 1'b1);
    for (int i = 0; i < NCAL; i++) begin
      cyc(1'b1, d, 1'b0);
      if (i == NCAL - 2) chk1("cal_not_done_15", cal_done, 1'b0);
    end
    chk1("cal_done_pulse", cal_done, 1'b1);
    chk1("cal_busy_off", busy, 1'b0);
    cyc(1'b0, d, 1'b0);
    chk1("cal_done_single", cal_done, 1'b0);
  endtask

  initial begin
    int k;
    #2 rst_n = 1'b0;
    #1;
    chk16("rst_offset", offset, 16'h8000);
    chk1("rst_out_valid", out_valid, 1'b0);
    chk16("rst_out_data", out_data, 16'h0000);
    chk1("rst_cal_ok", cal_ok, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    #9 rst_n = 1'b1;
    started = 1'b1;
    @(posedge clk); #1;

    // 1: uncalibrated conversion with mid-scale offset
    cyc(1'b1, 16'h8000, 1'b0);
    chk1("t1_valid", out_valid, 1'b1);
    chk16("t1_zero", out_data, 16'h0000);
    chk1("t1_cal_ok", cal_ok, 1'b0);
    cyc(1'b1, 16'h8005, 1'b0);
    chk16("t1_five", out_data, 16'h0005);

    // 2: basic calibration
    calibrate(16'h8123);
    chk16("t2_offset", offset, 16'h8123);
    chk1("t2_cal_ok", cal_ok, 1'b1);
    cyc(1'b1, 16'h8123, 1'b0);
    chk16("t2_zero", out_data, 16'h0000);
    cyc(1'b1, 16'h8120, 1'b0);
    chk16("t2_neg3", out_data, 16'hFFFD);

    // 3: gaps, truncation, ignored cal_start mid-sequence
    cyc(1'b0, 16'h0000, 1'b1);
    k = 0;
    for (int i = 0; i < 40 && k < NCAL; i++) begin
      if (i % 2 == 0) begin
        cyc(1'b1, (k % 2 == 0) ? 16'h1000 : 16'h1001, 1'b0);
        k++;
        if (k < NCAL) chk1("t3_busy", busy, 1'b1);
      end else begin
        cyc(1'b0, 16'hFFFF, (i == 11) ? 1'b1 : 1'b0);
      end
    end
    chk1("t3_done", cal_done, 1'b1);
    chk16("t3_offset", offset, 16'h1000);
    cyc(1'b1, 16'h1001, 1'b0);
    chk16("t3_one", out_data, 16'h0001);

    // 4: positive saturation
    calibrate(16'h0100);
    cyc(1'b1, 16'hFFFF, 1'b0);
    chk16("t4_pos_sat", out_data, 16'h7FFF);
    cyc(1'b1, 16'h0000, 1'b0);
    chk16("t4_neg256", out_data, 16'hFF00);

    // 5: negative saturation
    calibrate(16'hF000);
    cyc(1'b1, 16'h0000, 1'b0);
    chk16("t5_neg_sat", out_data, 16'h8000);
    cyc(1'b1, 16'hF7FF, 1'b0);
    chk16("t5_in_range", out_data, 16'h07FF);

    // 6: reset in the middle of a calibration
    cyc(1'b1, 16'h4000, 1'b1);
    for (int i = 0; i < 5; i++) cyc(1'b1, 16'h4000, 1'b0);
    rst_n = 1'b0;
    #1;
    chk16("t6_offset", offset, 16'h8000);
    chk1("t6_busy", busy, 1'b0);
    chk1("t6_cal_ok", cal_ok, 1'b0);
    chk1("t6_out_valid", out_valid, 1'b0);
    chk16("t6_out_data", out_data, 16'h0000);
    #5 rst_n = 1'b1;
    @(posedge clk); #1;
    calibrate(16'h2000);
    chk16("t6_new_offset", offset, 16'h2000);
    cyc(1'b1, 16'h2010, 1'b0);
    chk16("t6_conv", out_data, 16'h0010);

    cyc(1'b0, 16'h0000, 1'b0);
    cyc(1'b0, 16'h0000, 1'b0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
